// File: rtl/dataflow_pkg.sv
// dataflow_pkg: shared CGRA PE datapath constants and types.
// Default channel width/count and the output-buffer occupancy type.
package dataflow_pkg;

  localparam int DF_WIDTH = 32;
  localparam int DF_N     = 4;

  typedef logic [1:0] df_cnt_t;

endpackage

// File: rtl/dataflow_mux_if.sv
// dataflow_mux_if: select stream, N input channels and one output channel.
// master = traffic source/sink side, slave = the mux.
interface dataflow_mux_if
  import dataflow_pkg::*;
#(
  parameter int WIDTH = DF_WIDTH,
  parameter int N     = DF_N
);

  localparam int SEL_W = $clog2(N);

  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               sel_err;

  modport master (
    output sel_valid, sel, in_valid, in_data, out_ready,
    input  sel_ready, in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  sel_valid, sel, in_valid, in_data, out_ready,
    output sel_ready, in_ready, out_valid, out_data, sel_err
  );

endinterface

// File: rtl/dataflow_outbuf.sv
// dataflow_outbuf: output buffer of dataflow_mux, 1 entry or 2-entry skid.
// Ports: clk, reset, wr_en/wr_data (push), space, out_valid/out_ready/out_data.
// DATAFLOW_MUX_SKID_EN selects the 2-entry skid buffer (space from regs only).
module dataflow_outbuf
  import dataflow_pkg::*;
#(
  parameter int WIDTH = DF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             space,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

`ifdef DATAFLOW_MUX_SKID_EN

  df_cnt_t          cnt_q, cnt_d;
  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic             pop;

  assign pop       = (cnt_q != 2'd0) && out_ready;
  assign space     = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;

  // e0 is the head; e1 only holds data when two entries are queued.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop && wr_en) begin
      if (cnt_q == 2'd1) begin
        e0_d = wr_data;
      end else begin
        e0_d = e1_q;
        e1_d = wr_data;
      end
    end else if (pop) begin
      if (cnt_q == 2'd2) e0_d = e1_q;
      cnt_d = cnt_q - 2'd1;
    end else if (wr_en) begin
      if (cnt_q == 2'd0) e0_d = wr_data;
      else               e1_d = wr_data;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

`else

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Accept when empty or when the held entry leaves this cycle.
  assign space     = !v_q || out_ready;
  assign out_valid = v_q;
  assign out_data  = d_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (wr_en) begin
      v_d = 1'b1;
      d_d = wr_data;
    end else if (out_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

`endif

endmodule

// File: rtl/dataflow_mux.sv
// dataflow_mux: handshaked N-to-1 steering mux with registered output.
// Ports: clk, reset (async, high), bus (dataflow_mux_if.slave).
// Buffer depth set by DATAFLOW_MUX_SKID_EN inside dataflow_outbuf.
module dataflow_mux
  import dataflow_pkg::*;
#(
  parameter int WIDTH = DF_WIDTH,
  parameter int N     = DF_N
) (
  input  logic         clk,
  input  logic         reset,
  dataflow_mux_if.slave bus
);

  logic [31:0]      sel_ext;
  logic [N-1:0]     sel_oh;
  logic [WIDTH-1:0] mux_data;
  logic             in_range;
  logic             in_hit;
  logic             space;
  logic             fire_ok;
  logic             fire_bad;
  logic             sel_err_q, sel_err_d;

  assign sel_ext = 32'(bus.sel);

  always_comb begin
    sel_oh   = '0;
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh[i] = (sel_ext == 32'(i));
      mux_data  = mux_data
                | ({WIDTH{sel_oh[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
    end
  end

  // An empty one-hot means sel >= N (only reachable for non-pow2 N).
  assign in_range = |sel_oh;
  assign in_hit   = |(sel_oh & bus.in_valid);

  assign fire_ok  = !reset && space && bus.sel_valid
                 && in_range && in_hit;
  assign fire_bad = !reset && space && bus.sel_valid
                 && !in_range;

  assign bus.sel_ready = fire_ok || fire_bad;
  assign bus.in_ready  = fire_ok ? sel_oh : '0;

  assign sel_err_d   = sel_err_q || fire_bad;
  assign bus.sel_err = sel_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  dataflow_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (fire_ok),
    .wr_data   (mux_data),
    .space     (space),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data)
  );

endmodule

// File: tb/tb_dataflow_mux.sv
// tb_dataflow_mux: directed vectors and corner sequences for dataflow_mux.
// Main instance N=4/WIDTH=32, second instance N=3/WIDTH=8 for bad selects.
module tb_dataflow_mux;
  import dataflow_pkg::*;

`ifdef DATAFLOW_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dataflow_mux_if #(.WIDTH(32), .N(4)) bus ();
  dataflow_mux_if #(.WIDTH(8),  .N(3)) b3 ();

  dataflow_mux #(.WIDTH(32), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dataflow_mux #(.WIDTH(8), .N(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] dch(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h11;
  endfunction

  // sel must hold while its token is pending
  logic       pend_q = 1'b0;
  logic [1:0] psel_q = 2'd0;
  always @(negedge clk) begin
    if (!reset && pend_q && bus.sel_valid && bus.sel !== psel_q)
      $error("protocol: sel changed while select token pending");
    pend_q <= !reset && bus.sel_valid && !bus.sel_ready;
    psel_q <= bus.sel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sv;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic        e_sr;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic        cd;
    logic [31:0] e_od;
  } vec_t;

  vec_t vt[9];

  int          acc, got, limit;
  logic [31:0] base;

  task automatic run_cycle(input logic ordy, input string tag);
    logic inc;
    bus.sel           = 2'd0;
    bus.sel_valid     = (acc < limit);
    bus.in_valid      = 4'b0001;
    bus.in_data[31:0] = base + 32'(acc);
    bus.out_ready     = ordy;
    #1;
    inc = bus.in_ready[0];
    if (bus.out_valid && ordy) begin
      chk(tag, bus.out_data, base + 32'(got));
      got++;
    end
    @(posedge clk); #1;
    if (inc) acc++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0] = '{1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, dch(2)};
    vt[1] = '{1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, dch(2)};
    vt[2] = '{1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, dch(0)};
    vt[3] = '{1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b1, 2'd3, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, dch(3)};
    vt[5] = '{1'b1, 2'd1, 4'b1101, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};
    vt[6] = '{1'b1, 2'd1, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, dch(1)};
    vt[7] = '{1'b0, 2'd1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, dch(1)};
    vt[8] = '{1'b0, 2'd1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};

    // reset with traffic offered: everything gated
    reset         = 1'b1;
    bus.sel_valid = 1'b1;
    bus.sel       = 2'd2;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {dch(3), dch(2), dch(1), dch(0)};
    bus.out_ready = 1'b1;
    b3.sel_valid  = 1'b0;
    b3.sel        = 2'd0;
    b3.in_valid   = 3'b000;
    b3.in_data    = {8'h33, 8'h22, 8'h11};
    b3.out_ready  = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
    chk("rst_sel_ready", 32'(bus.sel_ready), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.sel_valid = 1'b0;
    step();
    reset = 1'b0;

    // table vectors
    for (int k = 0; k < 9; k++) begin
      bus.sel_valid = vt[k].sv;
      bus.sel       = vt[k].sel;
      bus.in_valid  = vt[k].iv;
      bus.out_ready = vt[k].ordy;
      #1;
      chk($sformatf("vec%0d_sel_ready", k),
          32'(bus.sel_ready), 32'(vt[k].e_sr));
      chk($sformatf("vec%0d_in_ready", k),
          32'(bus.in_ready), 32'(vt[k].e_ir));
      step();
      chk($sformatf("vec%0d_out_valid", k),
          32'(bus.out_valid), 32'(vt[k].e_ov));
      if (vt[k].cd)
        chk($sformatf("vec%0d_out_data", k), bus.out_data, vt[k].e_od);
    end

    // unselected channel 2 keeps waiting while 3,0,1 pass
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    foreach (vt[k]) if (k < 3) begin
      logic [1:0] s;
      s = (k == 0) ? 2'd3 : (k == 1) ? 2'd0 : 2'd1;
      bus.sel_valid = 1'b1;
      bus.sel       = s;
      #1;
      chk($sformatf("stall%0d_in_ready2", k), 32'(bus.in_ready[2]), 32'd0);
      chk($sformatf("stall%0d_sel_ready", k), 32'(bus.sel_ready), 32'd1);
      step();
      chk($sformatf("stall%0d_out_data", k), bus.out_data, dch(int'(s)));
    end
    bus.sel_valid = 1'b0;
    step();

    // reset while a token is buffered
    bus.sel_valid = 1'b1;
    bus.sel       = 2'd2;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b0;
    step();
    chk("pre_rst_buffered", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sel_ready", 32'(bus.sel_ready), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    bus.in_data[95:64] = 32'hA5A5_0001;
    bus.out_ready      = 1'b1;
    #1;
    chk("postrst_sel_ready", 32'(bus.sel_ready), 32'd1);
    step();
    chk("postrst_out_valid", 32'(bus.out_valid), 32'd1);
    chk("postrst_out_data", bus.out_data, 32'hA5A5_0001);
    bus.sel_valid = 1'b0;
    bus.in_data   = {dch(3), dch(2), dch(1), dch(0)};
    step();

    // backpressure: 5 stalled cycles, then drain
    acc = 0; got = 0; limit = 6; base = 32'h7000_0000;
    for (int c = 0; c < 5; c++) run_cycle(1'b0, "bp_order");
    chk("bp_accepted", 32'(acc), SKID ? 32'd2 : 32'd1);
    for (int c = 0; c < 20 && got < 6; c++) run_cycle(1'b1, "bp_order");
    chk("bp_drain_got", 32'(got), 32'd6);
    chk("bp_drain_acc", 32'(acc), 32'd6);
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // throughput: 100 tokens in 101 cycles
    acc = 0; got = 0; limit = 100; base = 32'h5000_0000;
    for (int c = 0; c < 101; c++) run_cycle(1'b1, "tput_order");
    chk("tput_acc", 32'(acc), 32'd100);
    chk("tput_got", 32'(got), 32'd100);
    bus.sel_valid = 1'b0;
    bus.in_data   = {dch(3), dch(2), dch(1), dch(0)};

    // simultaneous dequeue and fire
    bus.sel_valid = 1'b1;
    bus.sel       = 2'd1;
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b0;
    step();
    chk("dq_hold_data", bus.out_data, dch(1));
    bus.sel       = 2'd2;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    chk("dq_fire_ready", 32'(bus.sel_ready), 32'd1);
    step();
    chk("dq_out_valid", 32'(bus.out_valid), 32'd1);
    chk("dq_out_data", bus.out_data, dch(2));
    bus.sel       = 2'd3;
    bus.in_valid  = 4'b1000;
    bus.out_ready = 1'b0;
    #1;
    chk("dq_count_one", 32'(bus.sel_ready), SKID ? 32'd1 : 32'd0);
    step();
    chk("dq_order_head", bus.out_data, dch(2));
    bus.sel_valid = !SKID;
    bus.out_ready = 1'b1;
    step();
    chk("dq_order_next_valid", 32'(bus.out_valid), 32'd1);
    chk("dq_order_next", bus.out_data, dch(3));
    bus.sel_valid = 1'b0;
    step();
    chk("dq_empty", 32'(bus.out_valid), 32'd0);

    // bad select on the N=3 instance
    b3.sel_valid = 1'b1;
    b3.sel       = 2'd3;
    b3.in_valid  = 3'b111;
    #1;
    chk("bad_sel_ready", 32'(b3.sel_ready), 32'd1);
    chk("bad_in_ready", 32'(b3.in_ready), 32'd0);
    step();
    chk("bad_no_output", 32'(b3.out_valid), 32'd0);
    chk("bad_sel_err", 32'(b3.sel_err), 32'd1);
    b3.sel_valid = 1'b0;
    step();
    chk("bad_sel_err_held", 32'(b3.sel_err), 32'd1);
    b3.sel_valid = 1'b1;
    b3.sel       = 2'd1;
    #1;
    chk("bad_next_ready", 32'(b3.sel_ready), 32'd1);
    chk("bad_next_in_ready", 32'(b3.in_ready), 32'b010);
    step();
    chk("bad_next_valid", 32'(b3.out_valid), 32'd1);
    chk("bad_next_data", 32'(b3.out_data), 32'h22);
    chk("bad_sel_err_sticky", 32'(b3.sel_err), 32'd1);
    chk("main_sel_err_clear", 32'(bus.sel_err), 32'd0);
    b3.sel_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dataflow_mux.md
# dataflow_mux

Parametrised, handshaked N-to-1 steering multiplexer for the CGRA processing-element datapath and interconnect. Generalises the fixed 1-bit 4-to-1 combinational mux to N channels of WIDTH bits, each with valid/ready flow control. Selection comes from its own valid/ready token stream, and the output is registered. One select token plus the matching input token produce exactly one output token, in order.

## Interface
- WIDTH, default 32: data width per channel, ≥1.
- N, default 4: number of input channels, ≥2.
- SEL_W, localparam: $clog2(N).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately.
- sel_valid  in  1  select token present.
- sel_ready  out  1  select token consumed this cycle.
- sel  in  SEL_W  channel index.
- in_valid  in  N  per-channel token present.
- in_ready  out  N  per-channel token consumed this cycle.
- in_data  in  N×WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  output token present.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  output payload.
- sel_err  out  1  sticky flag: an out-of-range sel was consumed.

## Operation
- space: the output buffer can accept an entry this cycle (defined under Configuration).
- Fire, normal: space && sel_valid && sel<N && in_valid[sel].
  - sel_ready=1 and in_ready[sel]=1.
  - in_data[sel] is written to the output buffer.
- Fire, bad select: space && sel_valid && sel≥N. Only possible when N is not a power of two.
  - sel_ready=1; the token is dropped.
  - All in_ready=0; nothing is written.
  - sel_err is set on the next edge.
- Otherwise sel_ready=0 and all in_ready=0.
- in_ready[j] for j≠sel is always 0. Unselected tokens wait; they are never dropped or reordered.
- Ready outputs depend combinationally on sel_valid, sel, in_valid and buffer state. Upstream must not make valid depend on ready.
- Output tokens leave in fire order. out_data is stable while out_valid && !out_ready.
- sel_err clears only on reset.
- Reset values: out_valid=0, out_data=0, sel_err=0, buffer empty. While reset is high, sel_ready=0 and in_ready=0.

## Timing
- Latency: a fire at edge k gives out_valid=1 after edge k, carrying that data, unless older entries are still queued.
- Simultaneous dequeue and fire in one cycle:
  - The buffer count is unchanged.
  - The new entry queues behind the remaining ones.
- Reset mid-operation: buffered tokens are discarded and no partial transfer completes. The first fire is possible in the first cycle after reset deasserts.
- sel changing while sel_valid=1 and not fired is a protocol violation. Behaviour in that case is undefined; the bench asserts against it.

## Configuration
- DATAFLOW_MUX_SKID_EN defined: two-entry skid buffer.
  - space = (count<2), which depends on registers only.
  - No combinational path from out_ready to any ready output.
  - Sustains 1 token/cycle under continuous out_ready.
- Not defined: single-entry output register.
  - space = !out_valid || out_ready, a combinational out_ready→ready path.
  - Still sustains 1 token/cycle.
- Port list, ordering and latency are identical in both builds.

## Structure
- Shared package dataflow_pkg holds:
  - the default WIDTH and N constants;
  - a typedef for the buffer count (logic [1:0]).
  - Other PE blocks reuse these.
- One sub-module, dataflow_outbuf (WIDTH parameter): the 1- or 2-entry buffer.
  - Ports: clk, reset, wr_en, wr_data, space, out_valid, out_ready, out_data.
  - The macro is evaluated only inside this sub-module.
- The top level holds the select decode, the N-way data mux, ready generation and sel_err.

## Test plan
- Reset: assert reset with tokens buffered.
  - Immediately: out_valid=0, sel_err=0, all readies 0.
  - After release, sel=2 with in_data[2]=0xA5A5_0001 → out_data=0xA5A5_0001 one cycle later.
- Unselected stall: in_valid=4'b1111 and sel stream 3,0,1 with out_ready=1.
  - Outputs appear in order ch3, ch0, ch1.
  - in_ready[2] stays 0 throughout.
- Backpressure: out_ready=0 for 5 cycles with continuous tokens.
  - Skid build: exactly 2 tokens accepted. Non-skid build: 1 token accepted.
  - No token lost or duplicated after out_ready returns to 1.
- Throughput: 100 back-to-back tokens, out_ready=1 → 100 outputs in 101 cycles, in both builds.
- Bad select, N=3: sel=3 → sel_ready=1, no output, sel_err=1 on the next cycle and held. A following sel=1 passes data normally.
- Simultaneous dequeue and fire: buffer holding 1 entry, out_ready=1 and a new fire in the same cycle → count unchanged, data order preserved.
